sha_boot_sequencer: RTL and testbench
=====================================

// Module: sha_boot_sequencer
// PURPOSE
// Upstream feeder for the SHA-256 engine in the minimum security module. Accepts a boot image as a
// stream of 32-bit words, assembles 512-bit blocks, applies SHA-256 padding (word-aligned messages),
// drives the engine's init/next handshake, and compares the final digest with a golden digest to
// produce a boot pass/fail verdict for the boot control logic.
// PARAMETERS
// MAX_WORDS  4096  max message length in 32-bit words; longer stream -> error
// CNT_W      $clog2(MAX_WORDS+1)  width of word counter
// PORTS
// clk              in   1    system clock
// rst              in   1    synchronous active-high reset
// start            in   1    pulse in IDLE: begin new image hash
// msg_data         in   32   image word, big-endian (first byte in [31:24])
// msg_valid        in   1    msg_data valid
// msg_last         in   1    qualifies final word of image
// msg_ready        out  1    word accepted when msg_valid & msg_ready
// golden_digest    in   256  expected digest, sampled on start
// sha_block        out  512  block to engine; word 0 in [511:480]
// sha_init         out  1    1-cycle pulse, first block
// sha_next         out  1    1-cycle pulse, subsequent blocks
// sha_sel          out  1    tied 0 (normal hash, not PUF path)
// sha_ready        in   1    engine idle/ready
// sha_digest       in   256  engine digest
// busy             out  1    high in any state other than IDLE/DONE
// done             out  1    high in DONE until next start
// pass             out  1    valid when done: digest == golden
// error            out  1    valid when done: length overflow
// block_count      out  16   blocks issued for current image
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; sha_block, word index, counters, latched golden cleared.
// - States: IDLE, FILL, PAD, ISSUE, WAIT, CHECK, DONE.
// - IDLE: start -> latch golden, clear counters/block -> FILL. start while not IDLE/DONE ignored.
// - DONE: holds done/pass/error; start -> as in IDLE.
// - FILL: msg_ready=1. Accepted word written to block word idx (0..15), idx++, len++.
//   Word at idx 15 (not last) -> ISSUE, return to FILL. msg_last accepted -> pad_pending, then ISSUE
//   if idx was 15, else PAD. len reaching MAX_WORDS without last -> error=1, pass=0, DONE.
// - PAD (one cycle per block): if pad_pending, write 0x80000000 at idx, clear pad_pending; zero
//   words after it. If pad word at idx<=13 (or pad already placed in prior block and idx<=13):
//   words 14/15 = 64-bit bit length = len*32, final=1. Otherwise zero to 15, final=0. -> ISSUE.
// - ISSUE: wait sha_ready=1; pulse sha_init if block_count==0 else sha_next for exactly one cycle;
//   block_count++ -> WAIT. sha_block stable from ISSUE until WAIT exits.
// - WAIT: ignore sha_ready the cycle after the pulse; then on sha_ready=1: final -> CHECK;
//   else idx=0, clear block, -> PAD if message ended (length block pending), else FILL.
// - CHECK: pass = (sha_digest == golden), error=0 -> DONE next cycle.
// - Block counts: n words -> ceil((n+3)/16) blocks (pad word + 2 length words).
// - msg_ready=0 outside FILL; msg_valid outside FILL ignored, never backpressured by loss.
// - rst in any state (incl. WAIT mid-hash) returns to IDLE next cycle; engine pulse never issued
//   on the reset cycle; partial image discarded.
// - sha_init and sha_next never high simultaneously; at most one pulse per block.
// TESTING
// 1 word 0x61626364 ("abcd"), golden=SHA256("abcd") 88d4266f...031589 -> 1 init, block_count=1,
//   block word1=0x80000000, word15=0x20, pass=1.
// 13 words -> 1 block (len at 14/15); 14 words -> 2 blocks, 2nd block words 0..13 zero, word15=0x1C0.
// 16 words -> block 1 all data, block 2 word0=0x80000000, word15=0x200; 1 init + 1 next.
// Same "abcd", golden with bit 0 flipped -> done=1, pass=0, error=0.
// MAX_WORDS=8, 9 words with no last -> error=1 after 8th word, msg_ready=0 thereafter.
// rst asserted 3 cycles into WAIT -> IDLE, all outputs 0; new start hashes cleanly to pass.

Source files
------------

// File: rtl/sha_boot_sequencer.sv
// ---------------------------------------------------------------------------
// sha_boot_sequencer
//
// Streams a boot image, one 32-bit word at a time, into the SHA-256 engine.
// The image is packed into 512-bit blocks and SHA-256 padding is applied
// (the image is always a whole number of words). The engine is driven through
// its init/next handshake. The final digest is then compared with a golden
// digest, and the result is reported as a pass/fail boot verdict.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   start              pulse in IDLE/DONE: begin hashing a new image
//   msg_data/valid/last/ready
//                      image word stream, big-endian, valid/ready handshake
//   golden_digest      expected digest, sampled on start
//   sha_block          block presented to the engine, word 0 in [511:480]
//   sha_init/sha_next  one-cycle pulses: first block / subsequent blocks
//   sha_sel            engine mode select, always normal hash (0)
//   sha_ready          engine idle/ready
//   sha_digest         engine digest output
//   busy               high while an image is being processed
//   done, pass, error  verdict; pass/error are valid while done is high
//   block_count        number of blocks issued for the current image
// ---------------------------------------------------------------------------
module sha_boot_sequencer #(
   parameter int MAX_WORDS = 4096,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  msg_data,
   input  logic         msg_valid,
   input  logic         msg_last,
   output logic         msg_ready,
   input  logic [255:0] golden_digest,
   output logic [511:0] sha_block,
   output logic         sha_init,
   output logic         sha_next,
   output logic         sha_sel,
   input  logic         sha_ready,
   input  logic [255:0] sha_digest,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         error,
   output logic [15:0]  block_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_PAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE
   } state_e;

   localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_WORDS - 1);

   state_e         state_q;
   logic [3:0]     idx_q;          // next free word slot in block_q
   logic [CNT_W-1:0] len_q;        // words accepted for this image
   logic [511:0]   block_q;
   logic [255:0]   golden_q;
   logic           pad_pending_q;  // 0x80000000 marker not yet placed
   logic           msg_end_q;      // last word seen, padding block(s) still owed
   logic           final_q;        // block in flight carries the length field
   logic [1:0]     wait_cnt_q;     // cycles of sha_ready still to ignore
   logic [15:0]    blk_cnt_q;
   logic           init_q, next_q, done_q, pass_q, error_q;

   logic [511:0]   pad_block_d;
   logic           pad_final_d;
   logic [63:0]    bit_len;

   assign bit_len = 64'(len_q) << 5;

   // Padding block built from the current block: marker at idx_q if still
   // owed, zeros after it, and the bit length in words 14/15 when they are free.
   // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pad_block_d = block_q;
      for (int i = 0; i < 16; i++) begin
         if ((4'(i) == idx_q) && pad_pending_q)
            pad_block_d[(15 - i) * 32 +: 32] = 32'h8000_0000;
         else if (4'(i) >= idx_q)
            pad_block_d[(15 - i) * 32 +: 32] = 32'h0;
      end
      pad_final_d = (idx_q <= 4'd13);
      if (pad_final_d)
         pad_block_d[63:0] = bit_len;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the block register is reset as well, so that sha_block is 0 out of reset.
         state_q       <= S_IDLE;
         idx_q         <= '0;
         len_q         <= '0;
         block_q       <= '0;
         golden_q      <= '0;
         pad_pending_q <= 1'b0;
         msg_end_q     <= 1'b0;
         final_q       <= 1'b0;
         wait_cnt_q    <= '0;
         blk_cnt_q     <= '0;
         init_q        <= 1'b0;
         next_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         init_q <= 1'b0;
         next_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  golden_q      <= golden_digest;
                  idx_q         <= '0;
                  len_q         <= '0;
                  block_q       <= '0;
                  blk_cnt_q     <= '0;
                  pad_pending_q <= 1'b0;
                  msg_end_q     <= 1'b0;
                  final_q       <= 1'b0;
                  done_q        <= 1'b0;
                  pass_q        <= 1'b0;
                  error_q       <= 1'b0;
                  state_q       <= S_FILL;
               end
            end
            S_FILL: begin
               if (msg_valid) begin
                  block_q[{~idx_q, 5'b0} +: 32] <= msg_data;
                  len_q <= len_q + CNT_W'(1);
                  if (msg_last) begin
                     pad_pending_q <= 1'b1;
                     msg_end_q     <= 1'b1;
                     if (idx_q == 4'd15) begin
                        state_q <= S_ISSUE;
                     end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_PAD;
                     end
                  end else if (len_q == LEN_LAST) begin
                     // Image too long: abort with an error verdict.
                     error_q <= 1'b1;
                     pass_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else if (idx_q == 4'd15) begin
                     state_q <= S_ISSUE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            S_PAD: begin
               block_q       <= pad_block_d;
               final_q       <= pad_final_d;
               pad_pending_q <= 1'b0;
               state_q       <= S_ISSUE;
            end
            S_ISSUE: begin
               if (sha_ready) begin
                  if (blk_cnt_q == 16'd0) init_q <= 1'b1;
                  else                    next_q <= 1'b1;
                  blk_cnt_q  <= blk_cnt_q + 16'd1;
                  wait_cnt_q <= 2'd2;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // sha_ready is stale during the pulse cycle and the cycle after it.
               if (wait_cnt_q != 2'd0) begin
                  wait_cnt_q <= wait_cnt_q - 2'd1;
               end else if (sha_ready) begin
                  if (final_q) begin
                     state_q <= S_CHECK;
                  end else begin
                     idx_q   <= '0;
                     block_q <= '0;
                     state_q <= msg_end_q ? S_PAD : S_FILL;
                  end
               end
            end
            S_CHECK: begin
               pass_q  <= (sha_digest == golden_q);
               error_q <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign msg_ready   = (state_q == S_FILL);
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign sha_block   = block_q;
   assign sha_init    = init_q;
   assign sha_next    = next_q;
   assign sha_sel     = 1'b0;
   assign done        = done_q;
   assign pass        = pass_q;
   assign error       = error_q;
   assign block_count = blk_cnt_q;

endmodule

// File: tb/tb_sha_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sha_boot_sequencer
//
// Directed bench for sha_boot_sequencer. A behavioural SHA-256 engine serves
// the main instance. It computes real digests, so the "abcd" golden value
// checks the padding end to end. A second instance with MAX_WORDS=8 covers
// length overflow.
// ---------------------------------------------------------------------------
module tb_sha_boot_sequencer;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] ABCD_DIGEST =
      256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  msg_data = '0;
   logic         msg_valid = 1'b0;
   logic         msg_last = 1'b0;
   logic         msg_ready;
   logic [255:0] golden = '0;
   logic [511:0] sha_block;
   logic         sha_init, sha_next, sha_sel;
   logic         busy, done, pass, error;
   logic [15:0]  block_count;

   // small instance for the overflow case
   logic         s_start = 1'b0;
   logic [31:0]  s_msg_data = '0;
   logic         s_msg_valid = 1'b0;
   logic         s_msg_ready;
   logic [511:0] s_sha_block;
   logic         s_sha_init, s_sha_next, s_sha_sel;
   logic         s_busy, s_done, s_pass, s_error;
   logic [15:0]  s_block_count;

   // engine model state
   logic         eng_ready = 1'b1;
   int           eng_cnt = 0;
   logic [255:0] eng_h = '0;
   logic [511:0] cap [4];
   int           cap_n = 0;
   int           n_init = 0;
   int           n_next = 0;
   int           n_both = 0;

   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   sha_boot_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
      .golden_digest(golden), .sha_block(sha_block), .sha_init(sha_init), .sha_next(sha_next),
      .sha_sel(sha_sel), .sha_ready(eng_ready), .sha_digest(eng_h),
      .busy(busy), .done(done), .pass(pass), .error(error), .block_count(block_count));

   sha_boot_sequencer #(.MAX_WORDS(8)) dut_small (
      .clk(clk), .rst(rst), .start(s_start),
      .msg_data(s_msg_data), .msg_valid(s_msg_valid), .msg_last(1'b0), .msg_ready(s_msg_ready),
      .golden_digest(256'h0), .sha_block(s_sha_block), .sha_init(s_sha_init), .sha_next(s_sha_next),
      .sha_sel(s_sha_sel), .sha_ready(1'b1), .sha_digest(256'h0),
      .busy(s_busy), .done(s_done), .pass(s_pass), .error(s_error), .block_count(s_block_count));

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[(15 - i) * 32 +: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
         s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
   endfunction

   function automatic logic [31:0] img_word(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Reference digest of an n-word image built with textbook padding.
   function automatic logic [255:0] ref_digest(input int n);
      logic [31:0]  m [64];
      logic [511:0] blk;
      logic [255:0] h;
      int nb;
      nb = (n + 3 + 15) / 16;
      for (int i = 0; i < 64; i++) m[i] = 32'h0;
      for (int i = 0; i < n; i++) m[i] = img_word(i);
      m[n] = 32'h8000_0000;
      m[nb * 16 - 1] = 32'(n * 32);
      h = IV;
      for (int bi = 0; bi < nb; bi++) begin
         for (int wi = 0; wi < 16; wi++) blk[(15 - wi) * 32 +: 32] = m[bi * 16 + wi];
         h = compress(h, blk);
      end
      return h;
   endfunction

   function automatic logic [31:0] cword(input int b, input int w);
      logic [511:0] blk;
      blk = cap[b];
      return blk[(15 - w) * 32 +: 32];
   endfunction

   // Behavioural engine: latches the block on a pulse, stays busy for a few
   // cycles, and exposes the running digest.
   always @(posedge clk) begin
      if (start) begin
         cap_n  <= 0;
         n_init <= 0;
         n_next <= 0;
      end
      if (sha_init && sha_next) n_both <= n_both + 1;
      if (sha_init || sha_next) begin
         cap[cap_n & 3] <= sha_block;
         cap_n          <= cap_n + 1;
         if (sha_init) n_init <= n_init + 1;
         else          n_next <= n_next + 1;
         eng_h     <= compress(sha_init ? IV : eng_h, sha_block);
         eng_ready <= 1'b0;
         eng_cnt   <= 6;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_ready <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [255:0] g);
      @(negedge clk);
      golden = g;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      int guard;
      guard     = 0;
      msg_data  = w;
      msg_valid = 1'b1;
      msg_last  = last;
      while (!msg_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("send_in_time", 256'(guard < 200), 256'(1));
      @(negedge clk);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while (!done && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check(tag, 256'(guard < 2000), 256'(1));
   endtask

   task automatic run_image(input int n);
      do_start(ref_digest(n));
      for (int i = 0; i < n; i++) send_word(img_word(i), i == n - 1);
      wait_done("done_in_time");
   endtask

   initial begin
      int guard;

      // ---- reset state
      repeat (3) @(negedge clk);
      check("rst_busy",      256'(busy), 256'(0));
      check("rst_done",      256'(done), 256'(0));
      check("rst_pass",      256'(pass), 256'(0));
      check("rst_error",     256'(error), 256'(0));
      check("rst_msg_ready", 256'(msg_ready), 256'(0));
      check("rst_pulses",    256'({sha_init, sha_next, sha_sel}), 256'(0));
      check("rst_blk_cnt",   256'(block_count), 256'(0));
      check("rst_block_hi",  256'(sha_block[511:256]), 256'(0));
      check("rst_block_lo",  256'(sha_block[255:0]), 256'(0));
      rst = 1'b0;
      @(negedge clk);

      // ---- one word "abcd"
      do_start(ABCD_DIGEST);
      check("fill_busy",  256'(busy), 256'(1));
      check("fill_ready", 256'(msg_ready), 256'(1));
      send_word(32'h6162_6364, 1'b1);
      wait_done("abcd_done");
      check("abcd_pass",    256'(pass), 256'(1));
      check("abcd_error",   256'(error), 256'(0));
      check("abcd_busy",    256'(busy), 256'(0));
      check("abcd_blk_cnt", 256'(block_count), 256'(1));
      check("abcd_inits",   256'(n_init), 256'(1));
      check("abcd_nexts",   256'(n_next), 256'(0));
      check("abcd_w0",      256'(cword(0, 0)), 256'(32'h6162_6364));
      check("abcd_w1",      256'(cword(0, 1)), 256'(32'h8000_0000));
      check("abcd_w14",     256'(cword(0, 14)), 256'(0));
      check("abcd_w15",     256'(cword(0, 15)), 256'(32'h20));

      // ---- 13 words: one block, length fits
      run_image(13);
      check("w13_pass",    256'(pass), 256'(1));
      check("w13_blk_cnt", 256'(block_count), 256'(1));
      check("w13_w13",     256'(cword(0, 13)), 256'(32'h8000_0000));
      check("w13_w15",     256'(cword(0, 15)), 256'(32'h1A0));

      // ---- 14 words: marker in block 1, length-only block 2
      run_image(14);
      check("w14_pass",     256'(pass), 256'(1));
      check("w14_blk_cnt",  256'(block_count), 256'(2));
      check("w14_b0_w14",   256'(cword(0, 14)), 256'(32'h8000_0000));
      check("w14_b0_w15",   256'(cword(0, 15)), 256'(0));
      check("w14_b1_zero",  256'(cap[1][511:64]), 256'(0));
      check("w14_b1_w15",   256'(cword(1, 15)), 256'(32'h1C0));

      // ---- 16 words: full data block then marker + length block
      run_image(16);
      check("w16_pass",    256'(pass), 256'(1));
      check("w16_blk_cnt", 256'(block_count), 256'(2));
      check("w16_inits",   256'(n_init), 256'(1));
      check("w16_nexts",   256'(n_next), 256'(1));
      check("w16_b0_w15",  256'(cword(0, 15)), 256'(img_word(15)));
      check("w16_b1_w0",   256'(cword(1, 0)), 256'(32'h8000_0000));
      check("w16_b1_w15",  256'(cword(1, 15)), 256'(32'h200));

      // ---- wrong golden digest
      do_start(ABCD_DIGEST ^ 256'h1);
      send_word(32'h6162_6364, 1'b1);
      wait_done("bad_done");
      check("bad_done_flag", 256'(done), 256'(1));
      check("bad_pass",      256'(pass), 256'(0));
      check("bad_error",     256'(error), 256'(0));

      // ---- overflow on the MAX_WORDS=8 instance
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_msg_data  = 32'(i);
         s_msg_valid = 1'b1;
         if (i == 7) begin
            check("ovf_not_yet", 256'(s_error), 256'(0));
            check("ovf_ready7",  256'(s_msg_ready), 256'(1));
         end
         @(negedge clk);
      end
      check("ovf_error", 256'(s_error), 256'(1));
      check("ovf_done",  256'(s_done), 256'(1));
      check("ovf_pass",  256'(s_pass), 256'(0));
      check("ovf_ready", 256'(s_msg_ready), 256'(0));
      s_msg_data = 32'd8;
      repeat (2) @(negedge clk);
      check("ovf_ready_held", 256'(s_msg_ready), 256'(0));
      check("ovf_blk_cnt",    256'(s_block_count), 256'(0));
      s_msg_valid = 1'b0;

      // ---- reset while waiting on the engine
      do_start(ABCD_DIGEST);
      send_word(32'h6162_6364, 1'b1);
      guard = 0;
      while (!sha_init && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("mid_pulse_seen", 256'(guard < 100), 256'(1));
      repeat (3) @(negedge clk);
      check("mid_busy", 256'(busy), 256'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy",    256'(busy), 256'(0));
      check("mid_rst_flags",   256'({done, pass, error, msg_ready}), 256'(0));
      check("mid_rst_pulses",  256'({sha_init, sha_next}), 256'(0));
      check("mid_rst_blk_cnt", 256'(block_count), 256'(0));
      check("mid_rst_block",   256'(|sha_block), 256'(0));
      do_start(ABCD_DIGEST);
      send_word(32'h6162_6364, 1'b1);
      wait_done("rehash_done");
      check("rehash_pass",    256'(pass), 256'(1));
      check("rehash_blk_cnt", 256'(block_count), 256'(1));
      check("rehash_inits",   256'(n_init), 256'(1));

      check("no_dual_pulse", 256'(n_both), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
